// File: rtl/load_store_unit.sv
// Load/store unit: turns control-unit load/store requests into single-beat
// word-addressed bus transactions, with lane steering, load extension and
// alignment checking.
//
// Optional feature: define LSU_TIMEOUT_EN to add a watchdog that aborts a bus
// request after TIMEOUT_CYCLES cycles without mem_ack.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for exec_stage & (dbus_re | dbus_we)
// S_REQ  | bus request outstanding, request fields held in r_* regs
// S_DONE | one-cycle completion; access_fault visible here if flagged
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_exec_stage,
  input  logic        i_dbus_re,
  input  logic        i_dbus_we,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_access_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_byte_en,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_fault;
  logic [31:0] r_load_data;

  logic        w_start;
  logic        w_illegal;
  logic        w_timeout;
  logic [3:0]  w_lanes;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  assign w_start = i_exec_stage & (i_dbus_re | i_dbus_we);

  // Legality of the incoming request: size encoding, store-unsigned, dual
  // request and natural alignment.
  always_comb begin
    w_illegal = 1'b0;
    case (i_f3[1:0])
      2'b01:   w_illegal = i_addr[0];
      2'b10:   w_illegal = (i_addr[1:0] != 2'b00);
      2'b11:   w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
    if (i_dbus_we && i_f3[2]) w_illegal = 1'b1;
    if (i_dbus_re && i_dbus_we) w_illegal = 1'b1;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  // Ack takes priority: the abort fires only on a REQ cycle with no ack.
  assign w_timeout = (r_state == S_REQ) && !i_mem_ack &&
                     (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared on entry to REQ, counts REQ cycles without ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_REQ && !i_mem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and bus-facing outputs.
  always_comb begin
    w_next         = r_state;
    o_stall        = 1'b0;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_byte_en  = 4'b0000;
    o_access_fault = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          o_stall = 1'b1;
          w_next  = w_illegal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        o_stall       = 1'b1;
        o_mem_req     = 1'b1;
        o_mem_we      = r_we;
        o_mem_byte_en = w_lanes;
        if (i_mem_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        o_access_fault = r_fault;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lane enables and replicated write data from the latched request.
  always_comb begin
    case (r_f3[1:0])
      2'b00: begin
        w_lanes = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_lanes = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lanes = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Right-justify the addressed lane, then sign- or zero-extend.
  always_comb begin
    w_shifted = i_mem_rdata >> {r_addr[1:0], 3'b000};
    case (r_f3[1:0])
      2'b00:   w_load_ext = {{24{~r_f3[2] & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_ext = {{16{~r_f3[2] & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = i_mem_rdata;
    endcase
  end

  // Request capture, fault flag and load result register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_f3        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_fault     <= 1'b0;
      r_load_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_start) begin
        r_fault <= w_illegal;
        if (!w_illegal) begin
          r_addr  <= i_addr;
          r_f3    <= i_f3;
          r_wdata <= i_store_data;
          r_we    <= i_dbus_we;
        end
      end else if (w_timeout) begin
        r_fault <= 1'b1;
      end
      if (r_state == S_REQ && i_mem_ack && !r_we) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  assign o_mem_addr  = {r_addr[31:2], 2'b00};
  assign o_mem_wdata = w_wdata;
  assign o_load_data = r_load_data;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of REQ cycles without mem_ack before the watchdog aborts (used only with LSU_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 exec_stage  in  1  control-unit execute stage (driven from en_pc_counter).
REQ-005 dbus_re / dbus_we  in  1 each  load / store request from the control unit.
REQ-006 f3  in  3  access size [1:0] (00 byte, 01 half, 10 word); [2] = unsigned load.
REQ-007 addr  in  32  byte address from the ALU.
REQ-008 store_data  in  32  rs2 value.
REQ-009 stall  out  1  holds the control unit while an access is pending.
REQ-010 load_data  out  32  aligned, extended load result.
REQ-011 access_fault  out  1  one-cycle pulse on a misaligned, illegal or aborted access.
REQ-012 mem_req / mem_we  out  1 each  bus request / write qualifier.
REQ-013 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-014 mem_wdata  out  32, mem_byte_en  out  4  write data / byte lanes.
REQ-015 mem_ack  in  1, mem_rdata  in  32  bus completion / read data.

Function
REQ-016 States: IDLE, REQ, DONE.
REQ-017 start = exec_stage & (dbus_re | dbus_we); start is sampled only in IDLE.
REQ-018 stall = (IDLE & start) | REQ (combinational); stall is 0 in DONE.
REQ-019 IDLE & start & legal -> REQ; addr, f3, store_data and we are registered on that edge.
REQ-020 Illegal: f3[1:0]=11; store with f3[2]=1; dbus_re & dbus_we both high; half with addr[0]=1; word with addr[1:0]!=0.
REQ-021 IDLE & start & illegal -> DONE with access_fault=1 during DONE; no bus request; load_data unchanged.
REQ-022 In REQ: mem_req=1, and mem_addr, mem_we, mem_wdata and mem_byte_en are held stable until mem_ack.
REQ-023 REQ & mem_ack -> DONE; for loads, load_data is captured on that edge.
REQ-024 A mem_ack received outside REQ is ignored.
REQ-025 DONE -> IDLE unconditionally; minimum access latency is 2 cycles of stall.
REQ-026 Byte lanes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-027 Write data: mem_wdata is store_data[7:0] replicated x4 for byte, store_data[15:0] x2 for half, store_data as-is for word.
REQ-028 Load: the lane selected by addr[1:0] is right-justified, then sign-extended, or zero-extended when f3[2]=1.
REQ-029 load_data holds its value until the next successful load.

Reset
REQ-030 While rst is high, state=IDLE, mem_req=0, mem_we=0, mem_byte_en=0, access_fault=0, load_data=0, and registered request fields are 0.
REQ-031 Reset asserted in REQ drops mem_req immediately (asynchronously); the pending access is discarded with no fault.
REQ-032 After rst deasserts, the first posedge evaluates start in IDLE.

Configuration
REQ-033 With LSU_TIMEOUT_EN defined, a counter clears on entering REQ and increments each REQ cycle without mem_ack.
REQ-034 With LSU_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES: REQ -> DONE, mem_req=0, access_fault=1 in DONE, load_data unchanged.
REQ-035 If mem_ack arrives on the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins: no fault, and data is captured.
REQ-036 Without LSU_TIMEOUT_EN, no counter exists and REQ waits indefinitely for mem_ack.

Verification
REQ-037 Word load, addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> load_data=0xDEADBEEF, stall high 4 cycles, no fault.
REQ-038 lb at addr=0x103 with rdata=0x80FFFFFF -> load_data=0xFFFFFF80; lbu -> 0x00000080.
REQ-039 sh at addr=0x102, store_data=0x1234ABCD -> mem_addr=0x100, mem_byte_en=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-040 lw at addr=0x101 -> no mem_req, access_fault pulse, 1 stall cycle, load_data unchanged.
REQ-041 rst raised while in REQ -> mem_req low within the same cycle, state IDLE, subsequent load completes normally.
REQ-042 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> fault after 16 REQ cycles; ack on cycle 16 -> no fault.
